// File: rtl/clock_gate_ctrl.sv
// clock_gate_ctrl
//   Multi-channel idle-detecting clock-gate controller with latch-based ICGs.
//   Each channel counts consecutive idle cycles and closes its gated clock
//   once the programmed threshold is reached; it reopens on demand.
//   Channels flagged in CASCADE_MASK are clocked from channel 0's gated
//   clock, so channel 0 is held open while any of them is open or requesting.
//
// Ports
//   clk          root clock
//   rst_n        asynchronous active-low reset
//   req          per-channel activity request, sampled on clk rise
//   force_on     per-channel override, holds the channel in RUN
//   idle_thresh  per-channel idle threshold, channel i at [i*IDLE_W +: IDLE_W]
//   test_en      scan bypass, opens every ICG without touching the FSMs
//   gclk         gated clocks
//   gate_en      effective enable per channel (decoded from state registers)
//   ch_state     per-channel state, 2 bits each: RUN=0 IDLE=1 OFF=2 WAKE=3
//   wake_pulse   high for the single cycle a channel spends in WAKE
//
// State table
//   state | meaning
//   RUN   | clock open, channel active (or just woken)
//   IDLE  | clock open, counting idle cycles toward the threshold
//   OFF   | clock closed, waiting for demand
//   WAKE  | clock reopened, forced through to RUN so a wake is >=2 pulses

module clock_gate_ctrl #(
    parameter int                NUM_CH       = 4,
    parameter int                IDLE_W       = 8,
    parameter logic [NUM_CH-1:0] CASCADE_MASK = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        req,
    input  logic [NUM_CH-1:0]        force_on,
    input  logic [NUM_CH*IDLE_W-1:0] idle_thresh,
    input  logic                     test_en,
    output logic [NUM_CH-1:0]        gclk,
    output logic [NUM_CH-1:0]        gate_en,
    output logic [2*NUM_CH-1:0]      ch_state,
    output logic [NUM_CH-1:0]        wake_pulse
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_IDLE = 2'd1,
        ST_OFF  = 2'd2,
        ST_WAKE = 2'd3
    } ch_state_t;

    localparam logic [IDLE_W-1:0] CNT_MAX = '1;
    localparam logic [IDLE_W-1:0] CNT_ONE = IDLE_W'(1);

    ch_state_t         state_q [NUM_CH];
    ch_state_t         state_d [NUM_CH];
    logic [IDLE_W-1:0] cnt_q   [NUM_CH];
    logic [IDLE_W-1:0] cnt_d   [NUM_CH];

    logic [NUM_CH-1:0] is_child;
    logic [NUM_CH-1:0] demand;
    logic [NUM_CH-1:0] fsm_en;

    // Bit 0 of the mask is meaningless: channel 0 is always the root.
    always_comb begin
        is_child    = CASCADE_MASK;
        is_child[0] = 1'b0;
    end

    // Channel 0 must stay open while any child still needs its clock,
    // including a child that is merely open (RUN/IDLE/WAKE) without a request.
    always_comb begin
        demand = req | force_on;
        for (int c = 1; c < NUM_CH; c++) begin
            if (is_child[c] && (req[c] || force_on[c] || (state_q[c] != ST_OFF))) begin
                demand[0] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= ST_RUN;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // The threshold is compared live, so lowering it below the running count
    // gates on the very next edge. Demand is tested before the threshold so a
    // request arriving on the hit cycle keeps the channel running.
    always_comb begin
        logic [IDLE_W-1:0] thr;
        thr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            thr        = idle_thresh[i*IDLE_W +: IDLE_W];
            case (state_q[i])
                ST_RUN: begin
                    if (demand[i]) begin
                        cnt_d[i] = '0;
                    end else if (thr == '0) begin
                        state_d[i] = ST_OFF;
                        cnt_d[i]   = '0;
                    end else begin
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = CNT_ONE;
                    end
                end
                ST_IDLE: begin
                    if (demand[i]) begin
                        state_d[i] = ST_RUN;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] >= thr) begin
                        state_d[i] = ST_OFF;
                    end else if (cnt_q[i] != CNT_MAX) begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                ST_OFF: begin
                    if (demand[i]) begin
                        state_d[i] = ST_WAKE;
                    end
                end
                ST_WAKE: begin
                    state_d[i] = ST_RUN;
                    cnt_d[i]   = '0;
                end
                default: begin
                    state_d[i] = ST_RUN;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // Enables decode straight from the state registers, so they only move
    // just after a clk rise and settle well before the ICG latches open.
    always_comb begin
        fsm_en     = '0;
        gate_en    = '0;
        ch_state   = '0;
        wake_pulse = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            fsm_en[i]           = (state_q[i] != ST_OFF);
            ch_state[2*i +: 2]  = state_q[i];
            wake_pulse[i]       = (state_q[i] == ST_WAKE);
        end
        for (int i = 0; i < NUM_CH; i++) begin
            gate_en[i] = is_child[i] ? (fsm_en[i] & fsm_en[0]) : fsm_en[i];
        end
    end

    // Channel 0 ICG. Kept as its own net so children can be clocked from it
    // without feeding one bit of gclk back into another.
    logic lat_root;
    logic gclk_root;

    always_latch begin
        if (!rst_n) begin
            lat_root <= 1'b1;
        end else if (!clk) begin
            lat_root <= gate_en[0] | test_en;
        end
    end

    assign gclk_root = clk & lat_root;
    assign gclk[0]   = gclk_root;

    // Remaining ICGs: transparent while their own clock input is low, so an
    // enable change can only take effect during the low phase.
    for (genvar i = 1; i < NUM_CH; i++) begin : g_icg
        logic ck_in;
        logic lat_q;

        if (CASCADE_MASK[i]) begin : g_child
            assign ck_in = gclk_root;
        end else begin : g_root
            assign ck_in = clk;
        end

        always_latch begin
            if (!rst_n) begin
                lat_q <= 1'b1;
            end else if (!ck_in) begin
                lat_q <= gate_en[i] | test_en;
            end
        end

        assign gclk[i] = ck_in & lat_q;
    end

endmodule

// File: tb/tb_clock_gate_ctrl.sv
module tb_clock_gate_ctrl;

    localparam int         NUM_CH = 4;
    localparam int         IDLE_W = 8;
    localparam logic [3:0] CMASK  = 4'b0010;

    localparam int M_RUN  = 0;
    localparam int M_IDLE = 1;
    localparam int M_OFF  = 2;
    localparam int M_WAKE = 3;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  force_on;
    logic [31:0] idle_thresh;
    logic        test_en;
    logic [3:0]  gclk;
    logic [3:0]  gate_en;
    logic [7:0]  ch_state;
    logic [3:0]  wake_pulse;

    clock_gate_ctrl #(
        .NUM_CH      (NUM_CH),
        .IDLE_W      (IDLE_W),
        .CASCADE_MASK(CMASK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .force_on   (force_on),
        .idle_thresh(idle_thresh),
        .test_en    (test_en),
        .gclk       (gclk),
        .gate_en    (gate_en),
        .ch_state   (ch_state),
        .wake_pulse (wake_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int glitches = 0;
    logic [3:0] gclk_last = 4'b0;
    logic [3:0] last_gclk;
    logic [3:0] child_m;

    // A gated clock may only rise together with the root clock.
    always @(gclk) begin
        for (int i = 0; i < 4; i++) begin
            if (gclk[i] === 1'b1 && gclk_last[i] !== 1'b1 && clk !== 1'b1) glitches++;
        end
        gclk_last = gclk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural reference: per-channel mode and idle-run length as plain ints.
    int m_st  [4];
    int m_cnt [4];

    task automatic m_reset();
        for (int i = 0; i < 4; i++) begin
            m_st[i]  = M_RUN;
            m_cnt[i] = 0;
        end
    endtask

    function automatic logic [3:0] m_gate();
        logic [3:0] g;
        for (int i = 0; i < 4; i++) begin
            if (i > 0 && child_m[i]) g[i] = (m_st[i] != M_OFF) && (m_st[0] != M_OFF);
            else                     g[i] = (m_st[i] != M_OFF);
        end
        return g;
    endfunction

    function automatic logic [7:0] m_state_vec();
        logic [7:0] v;
        for (int i = 0; i < 4; i++) v[2*i +: 2] = 2'(m_st[i]);
        return v;
    endfunction

    function automatic logic [3:0] m_wake_vec();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = (m_st[i] == M_WAKE);
        return v;
    endfunction

    // Returns which gated clocks should pulse on this edge, then advances.
    task automatic m_advance(output logic [3:0] pulses);
        logic [3:0] g;
        logic [3:0] dem;
        int nst [4];
        int ncnt[4];
        int t;
        g = m_gate();
        for (int i = 0; i < 4; i++) pulses[i] = g[i] | test_en;
        for (int i = 1; i < 4; i++) if (child_m[i]) pulses[i] = pulses[i] & pulses[0];
        dem = req | force_on;
        for (int c = 1; c < 4; c++)
            if (child_m[c] && (req[c] || force_on[c] || m_st[c] != M_OFF)) dem[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            t       = int'(idle_thresh[i*8 +: 8]);
            nst[i]  = m_st[i];
            ncnt[i] = m_cnt[i];
            if (m_st[i] == M_RUN) begin
                if (dem[i])      ncnt[i] = 0;
                else if (t == 0) nst[i] = M_OFF;
                else begin nst[i] = M_IDLE; ncnt[i] = 1; end
            end else if (m_st[i] == M_IDLE) begin
                if (dem[i])              begin nst[i] = M_RUN; ncnt[i] = 0; end
                else if (m_cnt[i] >= t)  nst[i] = M_OFF;
                else                     ncnt[i] = (m_cnt[i] < 255) ? m_cnt[i] + 1 : 255;
            end else if (m_st[i] == M_OFF) begin
                if (dem[i]) nst[i] = M_WAKE;
            end else begin
                nst[i]  = M_RUN;
                ncnt[i] = 0;
            end
        end
        for (int i = 0; i < 4; i++) begin
            m_st[i]  = nst[i];
            m_cnt[i] = ncnt[i];
        end
    endtask

    task automatic step(input string tag);
        logic [3:0] exp_p;
        @(posedge clk);
        #1;
        last_gclk = gclk;
        m_advance(exp_p);
        chk({tag, " ch_state"},   ch_state,   m_state_vec());
        chk({tag, " gate_en"},    gate_en,    m_gate());
        chk({tag, " wake_pulse"}, wake_pulse, m_wake_vec());
        chk({tag, " gclk"},       last_gclk,  exp_p);
    endtask

    task automatic set_thr(input int ch, input int v);
        idle_thresh[ch*8 +: 8] = 8'(v);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        m_reset();
    endtask

    typedef struct {
        logic [3:0] req;
        logic [1:0] s2;
        logic [3:0] gen;
        logic [3:0] wake;
        logic       p2;
    } vec_t;

    vec_t tbl [12];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ch2 idles to OFF with threshold 3, wakes on a 1-cycle request, re-idles.
        tbl[0]  = '{4'h0, 2'd1, 4'hF, 4'h0, 1'b1};
        tbl[1]  = '{4'h0, 2'd1, 4'hF, 4'h0, 1'b1};
        tbl[2]  = '{4'h0, 2'd1, 4'hF, 4'h0, 1'b1};
        tbl[3]  = '{4'h0, 2'd2, 4'hB, 4'h0, 1'b1};
        tbl[4]  = '{4'h0, 2'd2, 4'hB, 4'h0, 1'b0};
        tbl[5]  = '{4'h4, 2'd3, 4'hF, 4'h4, 1'b0};
        tbl[6]  = '{4'h0, 2'd0, 4'hF, 4'h0, 1'b1};
        tbl[7]  = '{4'h0, 2'd1, 4'hF, 4'h0, 1'b1};
        tbl[8]  = '{4'h0, 2'd1, 4'hF, 4'h0, 1'b1};
        tbl[9]  = '{4'h0, 2'd1, 4'hF, 4'h0, 1'b1};
        tbl[10] = '{4'h0, 2'd2, 4'hB, 4'h0, 1'b1};
        tbl[11] = '{4'h0, 2'd2, 4'hB, 4'h0, 1'b0};

        child_m     = CMASK;
        rst_n       = 1'b0;
        req         = '0;
        force_on    = '0;
        idle_thresh = '0;
        test_en     = 1'b0;
        m_reset();

        repeat (3) @(posedge clk);
        #1;
        chk("reset ch_state",   ch_state,   8'h00);
        chk("reset gate_en",    gate_en,    4'hF);
        chk("reset wake_pulse", wake_pulse, 4'h0);
        chk("reset gclk high",  gclk,       4'hF);
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Table: threshold gating and wake on ch2; other channels forced.
        force_on = 4'b1011;
        set_thr(2, 3);
        for (int r = 0; r < 12; r++) begin
            req = tbl[r].req;
            step("tbl");
            chk($sformatf("tbl%0d ch2_state", r), ch_state[5:4], tbl[r].s2);
            chk($sformatf("tbl%0d gate_en", r),   gate_en,       tbl[r].gen);
            chk($sformatf("tbl%0d wake", r),      wake_pulse,    tbl[r].wake);
            chk($sformatf("tbl%0d gclk2", r),     last_gclk[2],  tbl[r].p2);
        end

        // Cascade: active child holds ch0 open; child OFF lets ch0 close 2 edges later.
        do_reset();
        force_on = 4'b1100;
        idle_thresh = '0;
        set_thr(0, 1);
        set_thr(1, 2);
        req = 4'b0010;
        for (int k = 0; k < 6; k++) begin
            step("casc hold");
            chk("casc ch0 open", ch_state[1:0], 2'd0);
        end
        req = 4'b0000;
        step("casc");
        step("casc");
        step("casc");
        chk("casc ch1 off",     ch_state[3:2], 2'd2);
        chk("casc ch0 run",     ch_state[1:0], 2'd0);
        step("casc");
        chk("casc ch0 idle",    ch_state[1:0], 2'd1);
        step("casc");
        chk("casc ch0 off",     ch_state[1:0], 2'd2);
        req = 4'b0010;
        step("casc wake");
        chk("casc joint wake",  wake_pulse[1:0], 2'b11);
        req = 4'b0000;
        step("casc");
        chk("casc both pulse",  last_gclk[1:0], 2'b11);

        // Threshold lowered mid-count gates on the next edge.
        do_reset();
        force_on = 4'b1011;
        req = '0;
        set_thr(2, 10);
        repeat (5) step("lower");
        chk("lower idle", ch_state[5:4], 2'd1);
        set_thr(2, 2);
        step("lower");
        chk("lower off", ch_state[5:4], 2'd2);

        // Demand on the threshold-hit edge keeps the channel running.
        do_reset();
        set_thr(2, 3);
        repeat (3) step("race");
        req = 4'b0100;
        step("race");
        chk("race run", ch_state[5:4], 2'd0);
        req = 4'b0000;

        // Test bypass: all OFF, test_en opens every clock without moving state.
        do_reset();
        force_on    = '0;
        idle_thresh = '0;
        repeat (2) step("scan");
        chk("scan all off", ch_state, 8'hAA);
        test_en = 1'b1;
        repeat (3) step("scan on");
        chk("scan state kept", ch_state, 8'hAA);
        chk("scan clocks run", last_gclk, 4'hF);
        test_en = 1'b0;
        repeat (2) step("scan off");
        chk("scan clocks stop", last_gclk, 4'h0);

        // Async reset while ch1 is OFF and clk is high.
        do_reset();
        force_on    = 4'b0001;
        idle_thresh = 32'h0505_0000;
        step("arst");
        step("arst");
        chk("arst ch1 off", ch_state[3:2], 2'd2);
        rst_n = 1'b0;
        #1;
        chk("arst gate_en", gate_en,  4'hF);
        chk("arst state",   ch_state, 8'h00);
        chk("arst gclk",    gclk,     4'hF);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        m_reset();
        set_thr(1, 2);
        step("arst rel");
        step("arst rel");
        chk("arst ch1 idle", ch_state[3:2], 2'd1);
        step("arst rel");
        chk("arst ch1 off2", ch_state[3:2], 2'd2);

        // Randomized traffic against the reference model.
        do_reset();
        force_on = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc % 40 == 0) begin
                for (int i = 0; i < 4; i++) set_thr(i, int'($urandom_range(0, 4)));
            end
            for (int i = 0; i < 4; i++) begin
                req[i]      = ($urandom_range(0, 5) == 0);
                force_on[i] = ($urandom_range(0, 19) == 0);
            end
            if ($urandom_range(0, 9) == 0) test_en = ~test_en;
            step("rand");
        end
        test_en = 1'b0;
        step("rand end");

        chk("glitch count", 32'(glitches), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
